morse_ram_arbiter: RTL and testbench
====================================

# morse_ram_arbiter

Sequences and shares the 16 x 10-bit morse RAM between three requesters: the player-1 writer, the player-2 reader and the VGA/translator display reader. It owns the write pointer, which also gives the code length, and the player-2 read pointer. It gates each player port by game phase and is the only block that drives the RAM's address, data and write-enable pins. It sits between the top-level game FSM and the synchronous RAM.

## Interface
- DEPTH, 16, RAM entries; also the maximum code length.
- AW, 4, address width, equal to log2(DEPTH).
- DW, 10, word width.
- clock  in  1  system clock; every port is sampled and driven on its rising edge.
- reset  in  1  synchronous, active-high reset.
- phase  in  2  game phase: 0 START, 1 P1TURN, 2 P2TURN, 3 RESULT.
- wr_req / wr_data  in  1 / DW  player-1 write request and word; held until wr_ack.
- wr_ack  out  1  one-cycle pulse when the word is written.
- rd_req  in  1  player-2 sequential read request; held until rd_ack.
- rd_ack  out  1  one-cycle pulse when the read is issued.
- rd_valid / rd_data  out  1 / DW  one-cycle pulse with the read word.
- disp_req / disp_addr  in  1 / AW  display random read request and address.
- disp_ack, disp_valid / disp_data  out  1, 1 / DW  same semantics as the player-2 read.
- ram_addr / ram_data / ram_wren  out  AW / DW / 1  RAM pins, all registered.
- ram_q  in  DW  RAM output, valid one cycle after ram_addr is presented.
- length  out  AW+1  number of words written (0..DEPTH).
- full, empty, rd_done  out  1  length==DEPTH; length==0; rd_ptr==length.
- overflow  out  1  one-cycle pulse when a write is refused because the RAM is full.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE → ISSUE when any legal request is pending.
- ISSUE → IDLE for a write; ISSUE → CAPTURE for a read.
- CAPTURE → IDLE always.
- Legal requests by phase:
  - wr_req only in phase 1, and only when !full.
  - rd_req only in phase 2, and only when !rd_done.
  - disp_req in any phase.
  - Illegal requests are ignored and never acknowledged.
- Arbitration, decided in IDLE, is round-robin between the phase-legal player request and disp_req. A `last_disp` bit starts at 0 after reset. When both are pending, the one not served last wins.
- At the grant edge, latch into registers: the chosen source, the address (wr_ptr, rd_ptr or disp_addr) and wr_data.
- Write: ram_wren=1 during ISSUE; wr_ptr and length increment at the end of ISSUE.
- Player read: rd_ptr increments at the end of ISSUE.
- Display read: no pointer change. If disp_addr ≥ length, disp_data is returned as 0.
- Entering phase 0 (phase==0 in IDLE) clears wr_ptr, length and rd_ptr.
- Entering phase 2 from any other phase clears rd_ptr.
- A phase change during ISSUE or CAPTURE lets the in-flight transaction finish. The new phase takes effect at the next IDLE.
- overflow pulses in IDLE when phase==1, wr_req==1 and full==1. It repeats every cycle while that condition holds.
- Reset values:
  - All outputs 0 except empty=1 and rd_done=1.
  - FSM returns to IDLE; pointers return to 0.
  - Any in-flight transaction is abandoned with no ack or valid.

## Timing
- Cycle t: IDLE with a request present; the grant is latched at the end of t.
- Cycle t+1 (ISSUE): ram_addr, ram_wren and ram_data are valid. The matching *_ack is high for this cycle only.
- Write completes in t+1; the next grant can occur in t+2, giving one write per 2 cycles.
- Read: ram_q is sampled at the end of t+2 (CAPTURE). *_valid and *_data are high in t+3; *_data holds its value until the next valid pulse.
- Read throughput is one per 3 cycles, and a new grant can be made in t+3.
- length, full, empty and rd_done update in the cycle after the pointer edge.
- A requester may drop its req only after seeing ack. A req dropped earlier is simply not granted.

## Structure
- The shared package `morse_pkg` holds:
  - the phase encodings PH_START, PH_P1, PH_P2, PH_RESULT, which are also used by the top FSM;
  - the FSM state encoding;
  - the DEPTH, AW and DW defaults.
- One sub-module, `rr_arb2`: a 2-way round-robin picker. Inputs are req[1:0] and an update strobe; output is a one-hot grant. It holds the last-served bit.
- The main module keeps the FSM, pointers, address/data mux and capture registers.

## Test plan
- Phase 1, three writes 0x001, 0x2AA, 0x3FF → three wr_ack pulses, each 2 cycles apart; ram_wren asserted at addresses 0, 1, 2; length=3.
- Switch to phase 2, issue 4 rd_req → rd_data 0x001, 0x2AA, 0x3FF, each arriving 2 cycles after its rd_ack. rd_done=1 after the third read; the fourth request is never acked.
- Phase 1, 17 back-to-back writes → 16 acks; full=1; overflow pulses while wr_req is held; RAM address 15 holds word 16.
- Phase 2 with rd_req and disp_req both held continuously → grants alternate player, display, player, … and neither starves.
- disp_addr=5 with length=3 → disp_valid asserted with disp_data=0.
- Reset asserted during CAPTURE → no rd_valid; next cycle all outputs at reset values; in phase 1, length starts again from 0.

Source files
------------

// File: rtl/morse_ram_arbiter_pkg.sv
// Shared definitions for the morse game blocks: phase encodings used by the
// top-level game FSM, the arbiter FSM state encoding and the RAM geometry.
package morse_pkg;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 10;
    localparam int unsigned LW    = AW + 1;  // holds 0..DEPTH

    typedef enum logic [1:0] {
        PH_START  = 2'd0,
        PH_P1     = 2'd1,
        PH_P2     = 2'd2,
        PH_RESULT = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_WR   = 2'd0,
        SRC_RD   = 2'd1,
        SRC_DISP = 2'd2
    } src_t;

endpackage

// File: rtl/morse_ram_arbiter_if.sv
// Bundle of every requester, status and RAM-pin signal around the arbiter.
//   slave  : the arbiter (drives acks, read data, status and RAM pins)
//   master : game FSM, players, display and the RAM (drive requests and ram_q)
interface morse_ram_arbiter_if;
    import morse_pkg::*;

    phase_t          phase;
    logic            wr_req;
    logic [DW-1:0]   wr_data;
    logic            wr_ack;
    logic            rd_req;
    logic            rd_ack;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            disp_req;
    logic [AW-1:0]   disp_addr;
    logic            disp_ack;
    logic            disp_valid;
    logic [DW-1:0]   disp_data;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data;
    logic            ram_wren;
    logic [DW-1:0]   ram_q;
    logic [AW:0]     length;
    logic            full;
    logic            empty;
    logic            rd_done;
    logic            overflow;

    modport slave (
        input  phase, wr_req, wr_data, rd_req, disp_req, disp_addr, ram_q,
        output wr_ack, rd_ack, rd_valid, rd_data, disp_ack, disp_valid, disp_data,
               ram_addr, ram_data, ram_wren, length, full, empty, rd_done, overflow
    );

    modport master (
        output phase, wr_req, wr_data, rd_req, disp_req, disp_addr, ram_q,
        input  wr_ack, rd_ack, rd_valid, rd_data, disp_ack, disp_valid, disp_data,
               ram_addr, ram_data, ram_wren, length, full, empty, rd_done, overflow
    );

endinterface

// File: rtl/morse_ram_arbiter_rr_arb2.sv
// Two-way round-robin picker. req[0] = player, req[1] = display.
// Ports: clock, reset (sync, active high), req, update (commit the grant),
//        grant_c (combinational one-hot grant).
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant_c
);

    logic last_disp;

    // On contention the side not served last wins.
    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = last_disp ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_disp <= 1'b0;
        end else if (update) begin
            last_disp <= grant_c[1];
        end
    end

endmodule

// File: rtl/morse_ram_arbiter.sv
// Shares the 16 x 10-bit morse RAM between the player-1 writer, the player-2
// sequential reader and the display random reader. Owns the write pointer
// (which is the code length) and the player-2 read pointer, gates the player
// ports by game phase and solely drives the RAM pins.
// Ports: clock, reset (sync, active high), bus (slave side of
//        morse_ram_arbiter_if: requests, acks, read data, status, RAM pins).
module morse_ram_arbiter
    import morse_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    morse_ram_arbiter_if.slave  bus
);

    state_t          state, state_n;
    src_t            src;
    phase_t          prev_phase;
    logic [LW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [LW-1:0]   len_eff, rd_ptr_eff;
    logic            wr_legal, rd_legal, disp_legal;
    logic [1:0]      grant_c;
    logic            grant_wr, grant_rd, grant_disp;
    logic            overflow_n, disp_oob;
    logic            full_q, empty_q, rd_done_q, overflow_q;
    logic            wr_ack_q, rd_ack_q, disp_ack_q;
    logic            rd_valid_q, disp_valid_q, ram_wren_q;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_data_q, rd_data_q, disp_data_q;

    // Phase-dependent pointer clears and request qualification; only in IDLE,
    // so a phase change never disturbs an in-flight transaction.
    always_comb begin
        len_eff    = wr_ptr;
        rd_ptr_eff = rd_ptr;
        wr_legal   = 1'b0;
        rd_legal   = 1'b0;
        disp_legal = 1'b0;
        overflow_n = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.phase == PH_START) begin
                len_eff    = '0;
                rd_ptr_eff = '0;
            end
            if (bus.phase == PH_P2 && prev_phase != PH_P2) begin
                rd_ptr_eff = '0;
            end
            wr_legal   = (bus.phase == PH_P1) && bus.wr_req && !full_q;
            rd_legal   = (bus.phase == PH_P2) && bus.rd_req && (rd_ptr_eff != len_eff);
            disp_legal = bus.disp_req;
            overflow_n = (bus.phase == PH_P1) && bus.wr_req && full_q;
        end
    end

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({disp_legal, wr_legal | rd_legal}),
        .update  (|grant_c),
        .grant_c (grant_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and grant decode.
    always_comb begin
        state_n    = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        grant_disp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_c[1]) begin
                    grant_disp = 1'b1;
                    state_n    = ST_ISSUE;
                end else if (grant_c[0]) begin
                    grant_wr = wr_legal;
                    grant_rd = rd_legal;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_n = (src == SRC_WR) ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Pointer advance at the end of ISSUE.
    always_comb begin
        wr_ptr_n = len_eff;
        rd_ptr_n = rd_ptr_eff;
        if (state == ST_ISSUE && src == SRC_WR) begin
            wr_ptr_n = wr_ptr + LW'(1);
        end
        if (state == ST_ISSUE && src == SRC_RD) begin
            rd_ptr_n = rd_ptr + LW'(1);
        end
    end

    // Grant latch, RAM pins, read capture and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            src          <= SRC_WR;
            prev_phase   <= PH_START;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            rd_done_q    <= 1'b1;
            overflow_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            disp_ack_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            ram_wren_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            rd_data_q    <= '0;
            disp_data_q  <= '0;
            disp_oob     <= 1'b0;
        end else begin
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            disp_ack_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            ram_wren_q   <= 1'b0;
            overflow_q   <= overflow_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            full_q       <= (wr_ptr_n == LW'(DEPTH));
            empty_q      <= (wr_ptr_n == '0);
            rd_done_q    <= (rd_ptr_n == wr_ptr_n);
            if (state == ST_IDLE) begin
                prev_phase <= bus.phase;
            end
            if (grant_wr) begin
                src        <= SRC_WR;
                ram_addr_q <= wr_ptr[AW-1:0];
                ram_data_q <= bus.wr_data;
                ram_wren_q <= 1'b1;
                wr_ack_q   <= 1'b1;
            end
            if (grant_rd) begin
                src        <= SRC_RD;
                ram_addr_q <= rd_ptr_eff[AW-1:0];
                rd_ack_q   <= 1'b1;
            end
            if (grant_disp) begin
                src        <= SRC_DISP;
                ram_addr_q <= bus.disp_addr;
                disp_ack_q <= 1'b1;
                // Addresses past the written code read back as zero.
                disp_oob   <= ({1'b0, bus.disp_addr} >= len_eff);
            end
            if (state == ST_CAPTURE) begin
                if (src == SRC_RD) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= bus.ram_q;
                end else if (src == SRC_DISP) begin
                    disp_valid_q <= 1'b1;
                    disp_data_q  <= disp_oob ? '0 : bus.ram_q;
                end
            end
        end
    end

    assign bus.wr_ack     = wr_ack_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.disp_ack   = disp_ack_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.length     = wr_ptr;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.rd_done    = rd_done_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_morse_ram_arbiter.sv
// Directed bench for morse_ram_arbiter with a behavioural synchronous RAM.
module tb_morse_ram_arbiter;
    import morse_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] words [3] = '{10'h001, 10'h2AA, 10'h3FF};

    morse_ram_arbiter_if bus ();

    morse_ram_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end

    // Synchronous RAM: q valid one cycle after the address.
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic wait_ack(input int which, input int limit, output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clock);
            if ((which == 0 && bus.wr_ack) || (which == 1 && bus.rd_ack) ||
                (which == 2 && bus.disp_ack)) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.phase = PH_START;
        bus.wr_req = 1'b0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.disp_req = 1'b0; bus.disp_addr = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total_cnt++;
        if ({bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.disp_ack, bus.disp_valid, bus.ram_wren, bus.overflow} !== 7'b0)
            $display("FAIL reset_pulses: got %b required 0000000", {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.disp_ack, bus.disp_valid, bus.ram_wren, bus.overflow});
        else pass_cnt++;
        total_cnt++;
        if ({bus.length, bus.full, bus.empty, bus.rd_done} !== {5'd0, 1'b0, 1'b1, 1'b1})
            $display("FAIL reset_status: got len=%0d full=%b empty=%b rd_done=%b required 0 0 1 1", bus.length, bus.full, bus.empty, bus.rd_done);
        else pass_cnt++;
        total_cnt++;
        if ({bus.ram_addr, bus.ram_data, bus.rd_data, bus.disp_data} !== '0)
            $display("FAIL reset_data: got addr=%0h data=%0h rd=%0h disp=%0h required all 0", bus.ram_addr, bus.ram_data, bus.rd_data, bus.disp_data);
        else pass_cnt++;
    endtask

    task automatic test_writes();
        bit seen;
        int at, prev_at;
        prev_at = 0;
        bus.phase = PH_P1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_req = 1'b1;
            bus.wr_data = words[i];
            wait_ack(0, 8, seen, at);
            total_cnt++;
            if (!seen) $display("FAIL wr_ack_%0d: got no ack in 8 cycles required an ack", i);
            else pass_cnt++;
            total_cnt++;
            if ({bus.ram_wren, bus.ram_addr, bus.ram_data} !== {1'b1, 4'(i), words[i]})
                $display("FAIL wr_pins_%0d: got wren=%b addr=%0d data=%0h required 1 %0d %0h", i, bus.ram_wren, bus.ram_addr, bus.ram_data, i, words[i]);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (at - prev_at != 2) $display("FAIL wr_spacing_%0d: got %0d cycles required 2", i, at - prev_at);
                else pass_cnt++;
            end
            prev_at = at;
        end
        bus.wr_req = 1'b0;
        @(negedge clock);
        total_cnt++;
        if ({bus.length, bus.empty, bus.full} !== {5'd3, 1'b0, 1'b0})
            $display("FAIL wr_length: got len=%0d empty=%b full=%b required 3 0 0", bus.length, bus.empty, bus.full);
        else pass_cnt++;
    endtask

    task automatic test_reads();
        bit seen;
        int at;
        bus.phase = PH_P2;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req = 1'b1;
            wait_ack(1, 8, seen, at);
            bus.rd_req = 1'b0;
            total_cnt++;
            if (!seen || bus.ram_addr !== 4'(i))
                $display("FAIL rd_ack_%0d: got seen=%b addr=%0d required 1 %0d", i, seen, bus.ram_addr, i);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if (bus.rd_valid !== 1'b0) $display("FAIL rd_early_%0d: got rd_valid=1 one cycle after ack required 0", i);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, words[i]})
                $display("FAIL rd_data_%0d: got valid=%b data=%0h required 1 %0h", i, bus.rd_valid, bus.rd_data, words[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.rd_done !== (i == 2)) $display("FAIL rd_done_%0d: got %b required %b", i, bus.rd_done, i == 2);
            else pass_cnt++;
        end
        bus.rd_req = 1'b1;
        wait_ack(1, 8, seen, at);
        bus.rd_req = 1'b0;
        total_cnt++;
        if (seen) $display("FAIL rd_past_end: got an ack required none");
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_data !== 10'h3FF) $display("FAIL rd_hold: got %0h required 3ff", bus.rd_data);
        else pass_cnt++;
    endtask

    task automatic test_disp();
        bit seen;
        int at;
        logic [AW-1:0] addrs [2] = '{4'd5, 4'd1};
        logic [DW-1:0] exps  [2] = '{10'h000, 10'h2AA};
        for (int i = 0; i < 2; i++) begin
            bus.disp_req = 1'b1;
            bus.disp_addr = addrs[i];
            wait_ack(2, 8, seen, at);
            bus.disp_req = 1'b0;
            total_cnt++;
            if (!seen) $display("FAIL disp_ack_%0d: got no ack required an ack", i);
            else pass_cnt++;
            repeat (2) @(negedge clock);
            total_cnt++;
            if ({bus.disp_valid, bus.disp_data} !== {1'b1, exps[i]})
                $display("FAIL disp_data_%0d: got valid=%b data=%0h required 1 %0h", i, bus.disp_valid, bus.disp_data, exps[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_alternate();
        int n, nr;
        bit seq [6];
        logic [DW-1:0] rvals [3];
        n = 0;
        nr = 0;
        bus.phase = PH_P1;
        repeat (2) @(negedge clock);
        bus.phase = PH_P2;
        bus.rd_req = 1'b1;
        bus.disp_req = 1'b1;
        bus.disp_addr = 4'd2;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            if (bus.rd_ack && n < 6) begin seq[n] = 1'b0; n++; end
            else if (bus.disp_ack && n < 6) begin seq[n] = 1'b1; n++; end
            if (bus.rd_valid && nr < 3) begin rvals[nr] = bus.rd_data; nr++; end
        end
        bus.rd_req = 1'b0;
        bus.disp_req = 1'b0;
        repeat (4) @(negedge clock);
        total_cnt++;
        if (n != 6 || nr != 3) $display("FAIL alt_count: got grants=%0d reads=%0d required 6 3", n, nr);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            total_cnt++;
            if (seq[i] !== 1'(i % 2)) $display("FAIL alt_order_%0d: got disp=%b required %b", i, seq[i], 1'(i % 2));
            else pass_cnt++;
        end
        for (int i = 0; i < nr; i++) begin
            total_cnt++;
            if (rvals[i] !== words[i]) $display("FAIL alt_rd_%0d: got %0h required %0h", i, rvals[i], words[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.disp_data !== 10'h3FF) $display("FAIL alt_disp: got %0h required 3ff", bus.disp_data);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        bit seen, seen17;
        int at, acks, ovf;
        acks = 0;
        ovf = 0;
        seen17 = 1'b0;
        bus.phase = PH_START;
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({bus.length, bus.empty, bus.rd_done} !== {5'd0, 1'b1, 1'b1})
            $display("FAIL start_clear: got len=%0d empty=%b rd_done=%b required 0 1 1", bus.length, bus.empty, bus.rd_done);
        else pass_cnt++;
        bus.phase = PH_P1;
        for (int k = 1; k <= 16; k++) begin
            bus.wr_req = 1'b1;
            bus.wr_data = DW'(k);
            wait_ack(0, 6, seen, at);
            if (seen) acks++;
        end
        bus.wr_data = DW'(17);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.wr_ack) seen17 = 1'b1;
            if (bus.overflow) ovf++;
        end
        bus.wr_req = 1'b0;
        total_cnt++;
        if (acks != 16 || seen17) $display("FAIL ovf_acks: got acks=%0d ack17=%b required 16 0", acks, seen17);
        else pass_cnt++;
        total_cnt++;
        if ({bus.full, bus.length} !== {1'b1, 5'd16}) $display("FAIL ovf_full: got full=%b len=%0d required 1 16", bus.full, bus.length);
        else pass_cnt++;
        total_cnt++;
        if (ovf != 9) $display("FAIL ovf_pulses: got %0d required 9", ovf);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL ovf_stop: got 1 required 0");
        else pass_cnt++;
        total_cnt++;
        if (mem[15] !== 10'd16 || mem[0] !== 10'd1) $display("FAIL ovf_ram: got [15]=%0d [0]=%0d required 16 1", mem[15], mem[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_capture();
        bit seen;
        int at;
        bus.phase = PH_P2;
        bus.rd_req = 1'b1;
        wait_ack(1, 8, seen, at);
        bus.rd_req = 1'b0;
        total_cnt++;
        if (!seen) $display("FAIL rc_ack: got no ack required an ack");
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total_cnt++;
        if ({bus.rd_valid, bus.rd_ack, bus.ram_wren, bus.length, bus.full, bus.empty, bus.rd_done} !== {3'b000, 5'd0, 3'b011})
            $display("FAIL rc_state: got valid=%b len=%0d full=%b empty=%b rd_done=%b required 0 0 0 1 1", bus.rd_valid, bus.length, bus.full, bus.empty, bus.rd_done);
        else pass_cnt++;
        reset = 1'b0;
        bus.phase = PH_P1;
        bus.wr_req = 1'b1;
        bus.wr_data = 10'h155;
        wait_ack(0, 8, seen, at);
        bus.wr_req = 1'b0;
        total_cnt++;
        if (!seen || bus.ram_addr !== 4'd0) $display("FAIL rc_write: got seen=%b addr=%0d required 1 0", seen, bus.ram_addr);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (bus.length !== 5'd1) $display("FAIL rc_length: got %0d required 1", bus.length);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_writes();
        test_reads();
        test_disp();
        test_alternate();
        test_overflow();
        test_reset_capture();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units required completion");
        $fatal(1);
    end

endmodule
